// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory answering the load/store
// port with a valid/ready request and response handshake. One request is in
// flight at a time, and a programmable number of wait states precede the access.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid / req_ready         request handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata  request payload, sampled at acceptance
//   resp_valid / resp_ready       response handshake (valid only in RESP)
//   resp_rdata, resp_error        load data (0 for stores/errors), error flag
module data_mem_responder #(
  parameter int unsigned ADDR_WORDS = 256,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned IDX_W = $clog2(ADDR_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [CNT_W-1:0]   waitCnt;
  logic               capWrite;
  logic [31:0]        capAddr;
  logic [31:0]        capWdata;
  logic [31:0]        mem [ADDR_WORDS];
  logic               accept;
  logic               doAccess;
  logic               accessErr;
  logic [IDX_W-1:0]   wordIdx;

  assign accept    = (state == IDLE) && req_valid;
  // WAIT spans LATENCY+1 edges, so the response appears LATENCY+1 edges after acceptance
  assign doAccess  = (state == WAIT) && (waitCnt == '0);
  // Misaligned or beyond the array; no aliasing of high addresses
  assign accessErr = (capAddr[1:0] != 2'b00) ||
                     ({1'b0, capAddr[31:2]} >= 31'(ADDR_WORDS));
  assign wordIdx   = capAddr[IDX_W+1:2];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req_valid)  stateNext = WAIT;
      WAIT:    if (doAccess)   stateNext = RESP;
      RESP:    if (resp_ready) stateNext = IDLE;
      default:                 stateNext = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE:    req_ready  = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture and wait-state counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt  <= '0;
      capWrite <= 1'b0;
      capAddr  <= '0;
      capWdata <= '0;
    end else if (accept) begin
      waitCnt  <= CNT_W'(LATENCY);
      capWrite <= req_write;
      capAddr  <= req_addr;
      capWdata <= req_wdata;
    end else if ((state == WAIT) && (waitCnt != '0)) begin
      waitCnt  <= waitCnt - CNT_W'(1);
    end
  end

  // Response registers: loaded once on entry to RESP, cleared on handoff
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else if (doAccess) begin
      resp_rdata <= (!accessErr && !capWrite) ? mem[wordIdx] : 32'h0;
      resp_error <= accessErr;
    end else if ((state == RESP) && resp_ready) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end
  end

  // Storage array: not reset, contents survive rst
  always_ff @(posedge clk) begin
    if (doAccess && capWrite && !accessErr) mem[wordIdx] <= capWdata;
  end

endmodule
